// File: rtl/rf_param.sv
// Parametrised register file with two combinational read ports, one write port and a clear sweep.
// Optional same-cycle write-through to the read ports when RF_BYPASS_EN is defined.
module rf_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              Reg_w,
    input  logic [ADDR_W-1:0] Rd_addr,
    input  logic [DATA_W-1:0] Rd_data,
    input  logic [ADDR_W-1:0] Rs_addr,
    input  logic [ADDR_W-1:0] Rt_addr,
    output logic [DATA_W-1:0] Rs_data,
    output logic [DATA_W-1:0] Rt_data,
    output logic              rf_ready
);
    localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A user write lands only in IDLE, when no clear is requested, and never on the hard-wired zero.
    assign wr_ok_c = (state == IDLE) && !clr && Reg_w && !is_zero_reg(Rd_addr);

    // Single array write port shared by the clear sweep and the Rd port.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = Rd_addr;
        mem_wdata_c = Rd_data;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we_c    = 1'b1;
                mem_addr_c  = clr_ptr;
                mem_wdata_c = '0;
            end else if (wr_ok_c) begin
                mem_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdata_c;
        end
    end

    // Sweep controller; rf_ready tracks IDLE as a registered decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            rf_ready <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_ADDR) begin
                        state    <= IDLE;
                        rf_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        rf_ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clr_ptr  <= '0;
                    rf_ready <= 1'b0;
                end
            endcase
        end
    end

    // Reads are zero while sweeping or when addressing the hard-wired zero register.
    always_comb begin
        Rs_data = '0;
        Rt_data = '0;
        if (rf_ready) begin
            if (!is_zero_reg(Rs_addr)) Rs_data = mem[Rs_addr];
            if (!is_zero_reg(Rt_addr)) Rt_data = mem[Rt_addr];
`ifdef RF_BYPASS_EN
            if (wr_ok_c && (Rd_addr == Rs_addr)) Rs_data = Rd_data;
            if (wr_ok_c && (Rd_addr == Rt_addr)) Rt_data = Rd_data;
`endif
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param: scoreboard of expected read values against a small array model.
module tb_rf_param;
    logic        clk = 1'b0;
    logic        rst, clr, Reg_w;
    logic [4:0]  Rd_addr, Rs_addr, Rt_addr;
    logic [31:0] Rd_data;
    logic [31:0] Rs_data, Rt_data, Rs_data_nz, Rt_data_nz;
    logic        rf_ready, rf_ready_nz;

    always #5 clk = ~clk;

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .Reg_w(Reg_w),
        .Rd_addr(Rd_addr), .Rd_data(Rd_data), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .Rs_data(Rs_data), .Rt_data(Rt_data), .rf_ready(rf_ready)
    );

    rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .clr(clr), .Reg_w(Reg_w),
        .Rd_addr(Rd_addr), .Rd_data(Rd_data), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .Rs_data(Rs_data_nz), .Rt_data(Rt_data_nz), .rf_ready(rf_ready_nz)
    );

    typedef struct {
        logic [31:0] s;
        logic [31:0] t;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    bit          model_idle;
    int          checks = 0;
    int          passed = 0;

    // Expected read value for the ZERO_REG=1 instance given the current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!model_idle || a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (Reg_w && !clr && !rst && Rd_addr == a) return Rd_data;
`endif
        return model[a];
    endfunction

    task automatic drive_read(input logic [4:0] as, input logic [4:0] at);
        Rs_addr = as;
        Rt_addr = at;
        exp_q.push_back('{exp_rd(as), exp_rd(at)});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        foreach (model[i]) model[i] = 32'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   first;
        first = 0;
        rst = 1'b1; clr = 1'b0; Reg_w = 1'b0;
        Rd_addr = '0; Rd_data = '0; Rs_addr = '0; Rt_addr = '0;
        model_idle = 1'b0;
        clear_model();
        tick();
        tick();
        checks++;
        if (rf_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", rf_ready);
        else passed++;
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 10) begin
                drive_read(5'd31, 5'd1);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (Rs_data !== e.s) $display("FAIL sweep_rs got %h want %h", Rs_data, e.s);
                else passed++;
                checks++;
                if (Rt_data !== e.t) $display("FAIL sweep_rt got %h want %h", Rt_data, e.t);
                else passed++;
            end
            if (rf_ready === 1'b1) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 32) $display("FAIL reset_ready_edge got %0d want 32", first);
        else passed++;
        model_idle = 1'b1;
        checks++;
        if (rf_ready_nz !== 1'b1) $display("FAIL nz_ready got %b want 1", rf_ready_nz);
        else passed++;
        for (int a = 0; a < 32; a++) begin
            drive_read(5'(a), 5'(31 - a));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (Rs_data !== e.s) $display("FAIL init_rs a=%0d got %h want %h", a, Rs_data, e.s);
            else passed++;
            checks++;
            if (Rt_data !== e.t) $display("FAIL init_rt a=%0d got %h want %h", 31 - a, Rt_data, e.t);
            else passed++;
            tick();
        end
    endtask

    task automatic test_write();
        exp_t e;
        Reg_w = 1'b1; Rd_addr = 5'd5; Rd_data = 32'hDEADBEEF;
        tick();
        model[5] = 32'hDEADBEEF;
        Reg_w = 1'b0;
        drive_read(5'd5, 5'd5);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL write_rs got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL write_rt got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
    endtask

    task automatic test_zero_reg();
        exp_t e;
        Reg_w = 1'b1; Rd_addr = 5'd0; Rd_data = 32'h1234;
        tick();
        Reg_w = 1'b0;
        drive_read(5'd0, 5'd5);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL zero_rs got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL zero_rt got %h want %h", Rt_data, e.t);
        else passed++;
        checks++;
        if (Rs_data_nz !== 32'h1234) $display("FAIL nz_r0 got %h want %h", Rs_data_nz, 32'h1234);
        else passed++;
        tick();
    endtask

    task automatic test_bypass();
        exp_t e;
        Reg_w = 1'b1; Rd_addr = 5'd7; Rd_data = 32'hA5A5A5A5;
        drive_read(5'd7, 5'd5);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL same_cycle_rs got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL same_cycle_rt got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
        model[7] = 32'hA5A5A5A5;
        Rd_addr = 5'd0; Rd_data = 32'hFFFFFFFF;
        drive_read(5'd0, 5'd7);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL zero_fwd_rs got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL after_write_rt got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
        Reg_w = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = $urandom();
            Reg_w = 1'b1; Rd_addr = 5'(10 + i); Rd_data = d;
            drive_read(5'(9 + i), 5'(20 + i));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (Rs_data !== e.s) $display("FAIL b2b_rs i=%0d got %h want %h", i, Rs_data, e.s);
            else passed++;
            checks++;
            if (Rt_data !== e.t) $display("FAIL b2b_rt i=%0d got %h want %h", i, Rt_data, e.t);
            else passed++;
            tick();
            model[10 + i] = d;
        end
        Reg_w = 1'b0;
        drive_read(5'd17, 5'd10);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL b2b_last got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL b2b_first got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
    endtask

    task automatic test_clear();
        exp_t e;
        int   first;
        first = 0;
        Reg_w = 1'b1; Rd_addr = 5'd3; Rd_data = 32'd9;
        tick();
        model[3] = 32'd9;
        Rd_addr = 5'd4; Rd_data = 32'd1; clr = 1'b1;
        tick();
        clr = 1'b0; Reg_w = 1'b0;
        clear_model();
        model_idle = 1'b0;
        checks++;
        if (rf_ready !== 1'b0) $display("FAIL clr_ready got %b want 0", rf_ready);
        else passed++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 20) begin
                Reg_w = 1'b1; Rd_addr = 5'd2; Rd_data = 32'd55;
                drive_read(5'd3, 5'd4);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (Rs_data !== e.s) $display("FAIL clr_sweep_rs got %h want %h", Rs_data, e.s);
                else passed++;
            end
            if (k == 21) Reg_w = 1'b0;
            if (rf_ready === 1'b1) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 32) $display("FAIL clr_ready_edge got %0d want 32", first);
        else passed++;
        model_idle = 1'b1;
        drive_read(5'd3, 5'd4);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL clr_r3 got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL clr_r4 got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
        drive_read(5'd2, 5'd7);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL clr_dropped_write got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL clr_r7 got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
    endtask

    task automatic test_rst_mid_sweep();
        exp_t e;
        int   first;
        first = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_idle = 1'b0;
        clear_model();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) begin
                Reg_w = 1'b1; Rd_addr = 5'd1; Rd_data = 32'd77;
            end
            if (k == 6) Reg_w = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rf_ready !== 1'b0) $display("FAIL rst_mid_ready got %b want 0", rf_ready);
        else passed++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rf_ready === 1'b1) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != 32) $display("FAIL rst_mid_ready_edge got %0d want 32", first);
        else passed++;
        model_idle = 1'b1;
        drive_read(5'd1, 5'd31);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (Rs_data !== e.s) $display("FAIL rst_mid_r1 got %h want %h", Rs_data, e.s);
        else passed++;
        checks++;
        if (Rt_data !== e.t) $display("FAIL rst_mid_r31 got %h want %h", Rt_data, e.t);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_clear();
        test_rst_mid_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout after %0d of %0d checks", passed, checks);
        $fatal(1);
    end

endmodule
